// File: rtl/ps2_mouse_ctrl_if.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl_if
// Handshake bundle between the mouse link sequencer and the PS/2 tx/rx units.
//   tx_idle      : transmitter can accept a byte
//   wr_ps2       : one-cycle load strobe for tx_data
//   tx_data      : command byte to transmit
//   rx_done_tick : one-cycle strobe, rx_data valid
//   rx_data      : byte received from the mouse
// master = sequencer side, slave = PS/2 phy side.
// ----------------------------------------------------------------------------
interface ps2_mouse_ctrl_if;
  logic       tx_idle;
  logic       wr_ps2;
  logic [7:0] tx_data;
  logic       rx_done_tick;
  logic [7:0] rx_data;

  modport master (
    input  tx_idle,
    input  rx_done_tick,
    input  rx_data,
    output wr_ps2,
    output tx_data
  );

  modport slave (
    output tx_idle,
    output rx_done_tick,
    output rx_data,
    input  wr_ps2,
    input  tx_data
  );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl
// Brings a PS/2 mouse up (reset 0xFF, BAT 0xAA, ID, enable 0xF4) through the
// existing tx/rx units, then decodes 3-byte stream packets into buttons and
// 9-bit two's-complement deltas. Init is retried on NAK-free failures
// (bad byte or timeout) up to MAX_RETRY attempts, after which err is raised.
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   re_init      : synchronous restart of the whole init sequence
//   ps2          : tx/rx handshake (master modport)
//   ready        : init complete, streaming packets
//   err          : retries exhausted, sticky until re_init/reset
//   btnm         : {M,R,L} buttons of the last packet
//   xm, ym       : deltas of the last packet
//   m_done_tick  : one-cycle strobe, new packet on btnm/xm/ym
// ----------------------------------------------------------------------------
module ps2_mouse_ctrl #(
  parameter int PWR_WAIT  = 500_000,
  parameter int TIMEOUT   = 2_500_000,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re_init,
  ps2_mouse_ctrl_if.master ps2,
  output logic             ready,
  output logic             err,
  output logic [2:0]       btnm,
  output logic [8:0]       xm,
  output logic [8:0]       ym,
  output logic             m_done_tick
);

  localparam int CNT_MAX = (PWR_WAIT > TIMEOUT) ? PWR_WAIT : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  localparam logic [7:0] CMD_RST = 8'hFF;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_NAK = 8'hFE;
  localparam logic [7:0] RSP_BAT = 8'hAA;

  typedef enum logic [3:0] {
    S_WAIT_PWR = 4'd0,
    S_SEND_RST = 4'd1,
    S_ACK_RST  = 4'd2,
    S_BAT      = 4'd3,
    S_ID       = 4'd4,
    S_SEND_EN  = 4'd5,
    S_ACK_EN   = 4'd6,
    S_PKT1     = 4'd7,
    S_PKT2     = 4'd8,
    S_PKT3     = 4'd9,
    S_FAIL     = 4'd10
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           wr_q, wr_d;
  logic [7:0]     txd_q, txd_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic [7:0]     b1_q, b1_d;
  logic [7:0]     b2_q, b2_d;
  logic [2:0]     btnm_q, btnm_d;
  logic [8:0]     xm_q, xm_d;
  logic [8:0]     ym_q, ym_d;
  logic           tick_q, tick_d;

  logic           rx_s;
  logic [7:0]     rxd_s;
  logic           to_s;
  logic           fail_s;

  assign rx_s  = ps2.rx_done_tick;
  assign rxd_s = ps2.rx_data;
  assign to_s  = (cnt_q == TO_LAST);

  // Next-state, counters and registered-output values.
  // The counter defaults to zero, so it is cleared on every state change and
  // only advances while a state is actively waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    wr_d    = 1'b0;
    txd_d   = txd_q;
    ready_d = ready_q;
    err_d   = err_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    btnm_d  = btnm_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    tick_d  = 1'b0;
    fail_s  = 1'b0;

    if (re_init) begin
      // packet outputs deliberately keep their last value
      state_d = S_WAIT_PWR;
      retry_d = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_PWR: begin
          if (cnt_q == PWR_LAST) state_d = S_SEND_RST;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        S_SEND_RST, S_SEND_EN: begin
          if (ps2.tx_idle) begin
            wr_d    = 1'b1;
            txd_d   = (state_q == S_SEND_RST) ? CMD_RST : CMD_EN;
            state_d = (state_q == S_SEND_RST) ? S_ACK_RST : S_ACK_EN;
          end else begin
            state_d = state_q;
          end
        end
        S_ACK_RST, S_ACK_EN: begin
          // a received byte takes precedence over a simultaneous timeout
          if (rx_s) begin
            if (rxd_s == RSP_ACK) begin
              state_d = (state_q == S_ACK_RST) ? S_BAT : S_PKT1;
              ready_d = (state_q == S_ACK_EN) ? 1'b1 : ready_q;
            end else if (rxd_s == RSP_NAK) begin
              state_d = (state_q == S_ACK_RST) ? S_SEND_RST : S_SEND_EN;
            end else begin
              fail_s = 1'b1;
            end
          end else if (to_s) begin
            fail_s = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BAT: begin
          if (rx_s) begin
            if (rxd_s == RSP_BAT) state_d = S_ID;
            else                  fail_s  = 1'b1;
          end else if (to_s) begin
            fail_s = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ID: begin
          if (rx_s)      state_d = S_SEND_EN;
          else if (to_s) fail_s  = 1'b1;
          else           cnt_d   = cnt_q + 1'b1;
        end
        S_PKT1: begin
          // bit3 is always set in a first packet byte; anything else resyncs
          if (rx_s && rxd_s[3]) begin
            b1_d    = rxd_s;
            state_d = S_PKT2;
          end else begin
            state_d = S_PKT1;
          end
        end
        S_PKT2: begin
          if (rx_s) begin
            b2_d    = rxd_s;
            state_d = S_PKT3;
          end else begin
            state_d = S_PKT2;
          end
        end
        S_PKT3: begin
          if (rx_s) begin
            btnm_d  = b1_q[2:0];
            xm_d    = {b1_q[4], b2_q};
            ym_d    = {b1_q[5], rxd_s};
            tick_d  = 1'b1;
            state_d = S_PKT1;
          end else begin
            state_d = S_PKT3;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_WAIT_PWR;
        end
      endcase

      if (fail_s) begin
        retry_d = retry_q + 1'b1;
        if (retry_q == RETRY_LAST) begin
          state_d = S_FAIL;
          err_d   = 1'b1;
        end else begin
          state_d = S_SEND_RST;
        end
      end else begin
        retry_d = retry_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT_PWR;
      cnt_q   <= '0;
      retry_q <= '0;
      wr_q    <= 1'b0;
      txd_q   <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      btnm_q  <= 3'b000;
      xm_q    <= 9'h000;
      ym_q    <= 9'h000;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      wr_q    <= wr_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      btnm_q  <= btnm_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      tick_q  <= tick_d;
    end
  end

  assign ps2.wr_ps2  = wr_q;
  assign ps2.tx_data = txd_q;
  assign ready       = ready_q;
  assign err         = err_q;
  assign btnm        = btnm_q;
  assign xm          = xm_q;
  assign ym          = ym_q;
  assign m_done_tick = tick_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_mouse_ctrl
// Drives the sequencer with a scripted/randomized mouse and checks it against
// a packet-level model (byte stream parse + arithmetic deltas) every cycle.
// ----------------------------------------------------------------------------
module tb_ps2_mouse_ctrl;
  localparam int PWR_WAIT  = 10;
  localparam int TIMEOUT   = 50;
  localparam int MAX_RETRY = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       re_init = 1'b0;
  logic       ready, err, m_done_tick;
  logic [2:0] btnm;
  logic [8:0] xm, ym;

  ps2_mouse_ctrl_if bus();

  ps2_mouse_ctrl #(.PWR_WAIT(PWR_WAIT), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .re_init(re_init), .ps2(bus),
    .ready(ready), .err(err), .btnm(btnm), .xm(xm), .ym(ym), .m_done_tick(m_done_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected-output model
  logic [2:0] exp_btnm = 3'd0;
  logic [8:0] exp_xm = 9'd0, exp_ym = 9'd0;
  logic       exp_tick = 1'b0, exp_ready = 1'b0, exp_err = 1'b0;
  bit         err_known = 1'b1, streaming = 1'b0, arm_ready = 1'b0;
  int         pk_n = 0;
  logic [7:0] pk [2];
  logic [7:0] cmd_q [$];

  // transmitter: busy for 5 cycles after each load strobe
  int busy = 0;
  always @(posedge clk) begin
    if (bus.wr_ps2 === 1'b1) busy <= 5;
    else if (busy > 0)       busy <= busy - 1;
  end
  assign bus.tx_idle = (busy == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
    end
  endtask

  function automatic logic [8:0] delta(input logic sgn, input logic [7:0] v);
    int d;
    d = int'(v) - (sgn ? 256 : 0);
    return 9'(d);
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (streaming) begin
      if (pk_n == 0) begin
        if (b[3]) begin pk[0] = b; pk_n = 1; end
      end else if (pk_n == 1) begin
        pk[1] = b; pk_n = 2;
      end else begin
        pk_n     = 0;
        exp_btnm = pk[0][2:0];
        exp_xm   = delta(pk[0][4], pk[1]);
        exp_ym   = delta(pk[0][5], b);
        exp_tick = 1'b1;
      end
    end
  endfunction

  function automatic void model_reinit();
    exp_ready = 1'b0; exp_err = 1'b0; exp_tick = 1'b0;
    streaming = 1'b0; pk_n = 0; err_known = 1'b1;
  endfunction

  // command monitor
  always begin
    @(posedge clk); #2;
    if (bus.wr_ps2 === 1'b1) cmd_q.push_back(bus.tx_data);
  end

  // per-cycle output compare
  always begin
    @(posedge clk); #2;
    check("btnm", {29'd0, btnm}, {29'd0, exp_btnm});
    check("xm", {23'd0, xm}, {23'd0, exp_xm});
    check("ym", {23'd0, ym}, {23'd0, exp_ym});
    check("m_done_tick", {31'd0, m_done_tick}, {31'd0, exp_tick});
    check("ready", {31'd0, ready}, {31'd0, exp_ready});
    if (err_known) check("err", {31'd0, err}, {31'd0, exp_err});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b; bus.rx_done_tick = 1'b1;
    model_rx(b);
    if (arm_ready) begin exp_ready = 1'b1; streaming = 1'b1; arm_ready = 1'b0; end
    @(negedge clk);
    bus.rx_done_tick = 1'b0; exp_tick = 1'b0;
  endtask

  task automatic wait_cmd(input logic [7:0] expb, input int budget, output int waited, input string name);
    logic [7:0] got;
    waited = 0;
    while (cmd_q.size() == 0 && waited < budget) begin
      @(posedge clk); #3; waited++;
    end
    if (cmd_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: no command within %0d cycles, want %02h", name, budget, expb);
    end else begin
      got = cmd_q.pop_front();
      check(name, {24'd0, got}, {24'd0, expb});
    end
  endtask

  task automatic pulse_re_init();
    @(negedge clk); re_init = 1'b1; model_reinit();
    @(negedge clk); re_init = 1'b0;
  endtask

  task automatic do_init(input string tag, input bit chk_lat);
    int w;
    wait_cmd(8'hFF, 200, w, {tag, "_cmd_rst"});
    if (chk_lat) check_range({tag, "_pwr_latency"}, w, 10, 14);
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
    wait_cmd(8'hF4, 200, w, {tag, "_cmd_en"});
    arm_ready = 1'b1; send_byte(8'hFA);
    idle(2);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_no_extra_cmd"}, cmd_q.size(), 32'd0);
  endtask

  task automatic rand_packets(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom) & 8'hF7;
        send_byte(b);
      end
      b = 8'($urandom) | 8'h08; send_byte(b); idle($urandom_range(0, 4));
      b = 8'($urandom);         send_byte(b); idle($urandom_range(0, 4));
      b = 8'($urandom);         send_byte(b); idle($urandom_range(0, 4));
    end
  endtask

  initial begin
    int w;
    bus.rx_done_tick = 1'b0; bus.rx_data = 8'h00;
    #1 reset = 1'b0;
    idle(3);
    check("rst_wr_ps2", {31'd0, bus.wr_ps2}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_ready_err", {30'd0, ready, err}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // happy path, including first-command latency after reset
    do_init("init1", 1'b1);

    // literal packet
    send_byte(8'h19); send_byte(8'h05); send_byte(8'hFE);
    idle(1);
    check("pkt_lit_btnm", {29'd0, btnm}, 32'h1);
    check("pkt_lit_xm", {23'd0, xm}, 32'h105);
    check("pkt_lit_ym", {23'd0, ym}, 32'h0FE);
    check("model_lit_xm", {23'd0, exp_xm}, 32'h105);

    // resync: leading byte without bit3 is dropped
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    idle(1);
    check("resync_xm", {23'd0, xm}, 32'h001);
    check("resync_ym", {23'd0, ym}, 32'h002);
    check("resync_btnm", {29'd0, btnm}, 32'h0);
    check("model_resync_ym", {23'd0, exp_ym}, 32'h002);

    rand_packets(40);

    // async reset while in the middle of a packet
    send_byte(8'h3B); idle(2);
    @(negedge clk); reset = 1'b0;
    exp_btnm = 3'd0; exp_xm = 9'd0; exp_ym = 9'd0;
    model_reinit(); cmd_q.delete();
    idle(2);
    check("pkt2_rst_outputs", {btnm, xm, ym, ready, err, m_done_tick}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // two failed attempts and two NAKs still end in ready
    wait_cmd(8'hFF, 200, w, "retry_cmd1");
    check_range("rst_pkt2_latency", w, 10, 14);
    send_byte(8'h55);
    wait_cmd(8'hFF, 200, w, "retry_cmd2");
    send_byte(8'hFA); send_byte(8'h12);
    wait_cmd(8'hFF, 200, w, "retry_cmd3");
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
    wait_cmd(8'hF4, 200, w, "nak_en1");
    send_byte(8'hFE);
    wait_cmd(8'hF4, 200, w, "nak_en2");
    send_byte(8'hFE);
    wait_cmd(8'hF4, 200, w, "nak_en3");
    arm_ready = 1'b1; send_byte(8'hFA);
    idle(2);
    check("nak_ready", {31'd0, ready}, 32'd1);
    check("nak_err", {31'd0, err}, 32'd0);
    rand_packets(10);

    // silent mouse: three reset attempts, then FAIL
    pulse_re_init();
    wait_cmd(8'hFF, 200, w, "to_cmd1");
    wait_cmd(8'hFF, 200, w, "to_cmd2");
    check_range("to_retry_gap", w, TIMEOUT - 5, TIMEOUT + 15);
    wait_cmd(8'hFF, 200, w, "to_cmd3");
    err_known = 1'b0;
    idle(TIMEOUT + 20);
    check("to_err", {31'd0, err}, 32'd1);
    exp_err = 1'b1; err_known = 1'b1;
    send_byte(8'hFA); send_byte(8'hAA);
    idle(200);
    check("fail_no_cmd", cmd_q.size(), 32'd0);
    check("fail_ready", {31'd0, ready}, 32'd0);

    // re_init out of FAIL
    pulse_re_init();
    do_init("init_refail", 1'b1);
    rand_packets(5);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
